// File: rtl/clk_freq_divider_pkg.sv
// -----------------------------------------------------------------------------
// clk_freq_divider_pkg
// Shared constants and helpers for the clock frequency divider.
//   DEFAULT_HALF_50 / _10 / _1 : input edges per half-period of each output
//                                (100 MHz in -> 50 MHz, 10 MHz, 1 MHz).
//   cnt_width(half)            : bits needed for a counter running 0..half-1,
//                                never less than one bit.
// -----------------------------------------------------------------------------
package clk_freq_divider_pkg;

    localparam int DEFAULT_HALF_50 = 1;
    localparam int DEFAULT_HALF_10 = 5;
    localparam int DEFAULT_HALF_1  = 50;

    // $clog2(1) is 0, which would give a zero-width counter; clamp to 1 bit.
    function automatic int cnt_width(input int half);
        return (half < 2) ? 1 : $clog2(half);
    endfunction

endpackage

// File: rtl/clk_freq_divider_toggle_div.sv
// -----------------------------------------------------------------------------
// clk_toggle_div
// Divides clk by 2*HALF, producing a registered 50 % duty square wave.
// The output toggles on every HALF-th rising edge after reset release.
// Ports:
//   clk     : input clock, rising edge
//   rst_n   : synchronous active-low reset (counter and output to 0)
//   clk_out : registered divided output
// -----------------------------------------------------------------------------
module clk_toggle_div
    import clk_freq_divider_pkg::*;
#(
    parameter int HALF = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_out
);

    localparam int             W       = cnt_width(HALF);
    localparam logic [W-1:0]   CNT_MAX = W'(HALF - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         out_q;
    logic         out_d;

    // Terminal count wraps the counter and flips the output in the same edge,
    // so the period is exactly 2*HALF input cycles with no drift.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        out_d = out_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            out_d = ~out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign clk_out = out_q;

endmodule

// File: rtl/clk_freq_divider.sv
// -----------------------------------------------------------------------------
// clk_freq_divider
// Derives three divided square waves from CLK_in for low-rate timing and
// strobe generation. Not meant to drive clock trees.
// Ports:
//   CLK_in : input clock (100 MHz nominal), rising edge
//   RST    : synchronous active-low reset
//   CLK_50 : CLK_in / (2*HALF_50)  (default /2)
//   CLK_10 : CLK_in / (2*HALF_10)  (default /10)
//   CLK_1  : CLK_in / (2*HALF_1)   (default /100)
// The three dividers are independent; sharing the reset keeps them in phase.
// -----------------------------------------------------------------------------
module clk_freq_divider
    import clk_freq_divider_pkg::*;
#(
    parameter int HALF_50 = DEFAULT_HALF_50,
    parameter int HALF_10 = DEFAULT_HALF_10,
    parameter int HALF_1  = DEFAULT_HALF_1
) (
    input  logic CLK_in,
    input  logic RST,
    output logic CLK_50,
    output logic CLK_10,
    output logic CLK_1
);

    clk_toggle_div #(.HALF(HALF_50)) u_div_50 (
        .clk     (CLK_in),
        .rst_n   (RST),
        .clk_out (CLK_50)
    );

    clk_toggle_div #(.HALF(HALF_10)) u_div_10 (
        .clk     (CLK_in),
        .rst_n   (RST),
        .clk_out (CLK_10)
    );

    clk_toggle_div #(.HALF(HALF_1)) u_div_1 (
        .clk     (CLK_in),
        .rst_n   (RST),
        .clk_out (CLK_1)
    );

endmodule

// File: tb/tb_clk_freq_divider.sv
// -----------------------------------------------------------------------------
// tb_clk_freq_divider
// Self-checking bench for clk_freq_divider: a default instance and one with
// HALF_10=3, HALF_1=7. Expected outputs come from the edge count since reset
// release: output = floor(n / HALF) mod 2.
// -----------------------------------------------------------------------------
module tb_clk_freq_divider;

    logic clk = 1'b0;
    logic RST = 1'b0;
    logic c50, c10, c1;
    logic o50, o10, o1;

    always #5 clk = ~clk;

    clk_freq_divider dut (
        .CLK_in (clk),
        .RST    (RST),
        .CLK_50 (c50),
        .CLK_10 (c10),
        .CLK_1  (c1)
    );

    clk_freq_divider #(.HALF_50(1), .HALF_10(3), .HALF_1(7)) dut_ovr (
        .CLK_in (clk),
        .RST    (RST),
        .CLK_50 (o50),
        .CLK_10 (o10),
        .CLK_1  (o1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   n           = 0;     // edges since reset release
    bit   model_valid = 1'b0;
    bit   edge_was_rst = 1'b0;

    always @(posedge clk) begin
        edge_was_rst <= !RST;
        if (!RST) begin
            n           <= 0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            n <= n + 1;
        end
    end

    // ---------------- compare process ----------------
    int   half_tab [6] = '{1, 5, 50, 1, 3, 7};
    logic [5:0] prev_obs;
    int   run_len [6];
    bit   run_ok  [6];

    always @(negedge clk) begin
        logic [5:0] obs;
        logic [5:0] tog;
        if (model_valid) begin
            obs = {o1, o10, o50, c1, c10, c50};
            for (int i = 0; i < 6; i++) begin
                check($sformatf("model_out%0d_n%0d", i, n), int'(obs[i]), (n / half_tab[i]) % 2);
            end
            if (edge_was_rst) begin
                for (int i = 0; i < 6; i++) begin
                    run_ok[i]  = 1'b0;
                    run_len[i] = 1;
                end
            end else begin
                tog = obs ^ prev_obs;
                // Each slower output must only toggle together with the faster one.
                if (tog[2]) check("phase_1_vs_10", int'(tog[1]), 1);
                if (tog[1]) check("phase_10_vs_50", int'(tog[0]), 1);
                for (int i = 0; i < 6; i++) begin
                    if (tog[i]) begin
                        if (run_ok[i]) check($sformatf("width_out%0d", i), run_len[i], half_tab[i]);
                        run_ok[i]  = 1'b1;
                        run_len[i] = 1;
                    end else begin
                        run_len[i]++;
                    end
                end
            end
            prev_obs = obs;
        end
    end

    // ---------------- stimulus ----------------
    int cp_n   [5] = '{1, 5, 18, 58, 99};
    int cp_exp [5] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b111};

    initial begin
        // Reset held for 4 cycles: all outputs 0 each cycle.
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_hold", int'({c50, c10, c1, o50, o10, o1}), 0);
        end
        RST = 1'b1;
        #1;
        check("pre_edge1", int'({c50, c10, c1}), 0);
        $display("reset released, checking checkpoints");

        // Checkpoints after edges 1, 5, 18, 58, 99.
        for (int k = 1; k <= 99; k++) begin
            @(negedge clk);
            for (int j = 0; j < 5; j++) begin
                if (k == cp_n[j]) begin
                    check($sformatf("checkpoint_n%0d", k), int'({c50, c10, c1}), cp_exp[j]);
                    $display("checkpoint n=%0d out=%b%b%b", k, c50, c10, c1);
                end
            end
        end

        // Free run; widths and phases are checked by the compare process.
        repeat (1000) @(negedge clk);
        $display("free run of 1000 cycles done");

        // Reset pulse at edge 37 of a fresh count.
        RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        repeat (36) @(negedge clk);
        check("pre_mid_rst_c10", int'(c10), 1);
        RST = 1'b0;
        @(negedge clk);
        check("mid_rst_zero", int'({c50, c10, c1}), 0);
        RST = 1'b1;
        repeat (4) @(negedge clk);
        check("rel_c10_edge4", int'(c10), 0);
        @(negedge clk);
        check("rel_c10_edge5", int'(c10), 1);
        repeat (44) @(negedge clk);
        check("rel_c1_edge49", int'(c1), 0);
        @(negedge clk);
        check("rel_c1_edge50", int'(c1), 1);
        $display("mid-run reset at edge 37 done");

        // Randomised run lengths and reset pulses.
        for (int r = 0; r < 20; r++) begin
            int run_cycles;
            int rst_cycles;
            run_cycles = int'($urandom_range(1, 250));
            rst_cycles = int'($urandom_range(1, 3));
            repeat (run_cycles) @(negedge clk);
            RST = 1'b0;
            repeat (rst_cycles) @(negedge clk);
            RST = 1'b1;
            $display("random seq %0d: run=%0d rst=%0d", r, run_cycles, rst_cycles);
        end
        repeat (300) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
